// File: rtl/pmu_snapshot_pkg.sv
// Shared types and constants for the PMU snapshot controller.
package pmu_snapshot_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      PUSH = 2'd3
   } state_t;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam int unsigned ADDR_STRIDE = 4;

endpackage

// File: rtl/pmu_snapshot_timer.sv
// Free-running period counter; emits a one-cycle tick every 'period' cycles.
module pmu_snapshot_timer #(
   parameter int unsigned PERIOD_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [PERIOD_WIDTH-1:0] period,
   output logic                    tick_c
);

   logic [PERIOD_WIDTH-1:0] count;
   logic                    run_c;

   // Tick on reaching the terminal count; >= also recovers if period shrinks below count.
   always_comb begin
      run_c  = en && (period != '0);
      tick_c = run_c && (count >= (period - PERIOD_WIDTH'(1)));
   end

   // Count while running, reload on tick, hold at zero when stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!run_c || tick_c) begin
         count <= '0;
      end else begin
         count <= count + PERIOD_WIDTH'(1);
      end
   end

endmodule

// File: rtl/pmu_snapshot_ctrl.sv
// Sweeps all PMU counters over AXI4-Lite reads and streams them out with their index.
module pmu_snapshot_ctrl
   import pmu_snapshot_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 7,
   parameter int unsigned N_COUNTERS         = 19,
   parameter int unsigned COUNTER_BASE       = 0,
   parameter int unsigned PERIOD_WIDTH       = 32
) (
   input  logic                               S_AXI_ACLK_i,
   input  logic                               S_AXI_ARESETN_i,
   input  logic                               en_i,
   input  logic [PERIOD_WIDTH-1:0]            period_i,
   input  logic                               trig_i,
   output logic                               busy_o,
   output logic                               drop_o,
   output logic                               err_o,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR_o,
   output logic                               M_AXI_ARVALID_o,
   input  logic                               M_AXI_ARREADY_i,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA_i,
   input  logic [1:0]                         M_AXI_RRESP_i,
   input  logic                               M_AXI_RVALID_i,
   output logic                               M_AXI_RREADY_o,
   output logic                               snap_valid_o,
   input  logic                               snap_ready_i,
   output logic [$clog2(N_COUNTERS)-1:0]      snap_idx_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      snap_data_o,
   output logic                               snap_last_o
);

   localparam int unsigned IDX_W = $clog2(N_COUNTERS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COUNTERS - 1);

   state_t state;
   logic   pending;
   logic   tick_c;
   logic   req_c;
   logic   consume_c;

   function automatic logic [C_S_AXI_ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] i);
      return C_S_AXI_ADDR_WIDTH'(COUNTER_BASE + ADDR_STRIDE * 32'(i));
   endfunction

   pmu_snapshot_timer #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_timer (
      .clk    (S_AXI_ACLK_i),
      .rst_n  (S_AXI_ARESETN_i),
      .en     (en_i),
      .period (period_i),
      .tick_c (tick_c)
   );

   // Merge timer and trigger into one request; IDLE consumes a pending request.
   always_comb begin
      req_c     = tick_c | (trig_i & en_i);
      consume_c = (state == IDLE) && pending;
   end

   // Request bookkeeping, sweep FSM and registered AXI/stream outputs.
   always_ff @(posedge S_AXI_ACLK_i or negedge S_AXI_ARESETN_i) begin
      if (!S_AXI_ARESETN_i) begin
         state           <= IDLE;
         pending         <= 1'b0;
         busy_o          <= 1'b0;
         drop_o          <= 1'b0;
         err_o           <= 1'b0;
         M_AXI_ARADDR_o  <= '0;
         M_AXI_ARVALID_o <= 1'b0;
         M_AXI_RREADY_o  <= 1'b0;
         snap_valid_o    <= 1'b0;
         snap_idx_o      <= '0;
         snap_data_o     <= '0;
         snap_last_o     <= 1'b0;
      end else begin
         drop_o <= req_c && pending && !consume_c;

         if (!en_i) begin
            pending <= 1'b0;
         end else if (consume_c) begin
            pending <= req_c;
         end else if (req_c) begin
            pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (pending) begin
                  snap_idx_o      <= '0;
                  M_AXI_ARADDR_o  <= addr_of('0);
                  M_AXI_ARVALID_o <= 1'b1;
                  busy_o          <= 1'b1;
                  state           <= ADDR;
               end
            end
            ADDR: begin
               if (M_AXI_ARREADY_i) begin
                  M_AXI_ARVALID_o <= 1'b0;
                  M_AXI_RREADY_o  <= 1'b1;
                  state           <= DATA;
               end
            end
            DATA: begin
               if (M_AXI_RVALID_i) begin
                  M_AXI_RREADY_o <= 1'b0;
                  snap_data_o    <= M_AXI_RDATA_i;
                  snap_valid_o   <= 1'b1;
                  snap_last_o    <= (snap_idx_o == LAST_IDX);
                  if (M_AXI_RRESP_i != RESP_OKAY) begin
                     err_o <= 1'b1;
                  end
                  state <= PUSH;
               end
            end
            PUSH: begin
               if (snap_ready_i) begin
                  snap_valid_o <= 1'b0;
                  snap_last_o  <= 1'b0;
                  if (snap_idx_o == LAST_IDX) begin
                     busy_o <= 1'b0;
                     state  <= IDLE;
                  end else begin
                     snap_idx_o      <= snap_idx_o + IDX_W'(1);
                     M_AXI_ARADDR_o  <= addr_of(snap_idx_o + IDX_W'(1));
                     M_AXI_ARVALID_o <= 1'b1;
                     state           <= ADDR;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmu_snapshot_ctrl.sv
// Directed bench for pmu_snapshot_ctrl with an AXI read slave model and a stream scoreboard.
module tb_pmu_snapshot_ctrl;

   localparam int unsigned N  = 19;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 7;
   localparam int unsigned PW = 32;

   typedef struct packed {
      logic [4:0]    idx;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [PW-1:0] period;
   logic          trig;
   logic          busy, drop, err;
   logic [AW-1:0] araddr;
   logic          arvalid, arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rvalid, rready;
   logic          snap_valid, snap_ready, snap_last;
   logic [4:0]    snap_idx;
   logic [DW-1:0] snap_data;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];
   logic [DW-1:0] mem [N];
   bit   rand_mode = 1'b0;
   bit   hold_ready = 1'b0;
   int   err_idx = -1;

   always #5 clk = ~clk;

   pmu_snapshot_ctrl dut (
      .S_AXI_ACLK_i    (clk),
      .S_AXI_ARESETN_i (rst_n),
      .en_i            (en),
      .period_i        (period),
      .trig_i          (trig),
      .busy_o          (busy),
      .drop_o          (drop),
      .err_o           (err),
      .M_AXI_ARADDR_o  (araddr),
      .M_AXI_ARVALID_o (arvalid),
      .M_AXI_ARREADY_i (arready),
      .M_AXI_RDATA_i   (rdata),
      .M_AXI_RRESP_i   (rresp),
      .M_AXI_RVALID_i  (rvalid),
      .M_AXI_RREADY_o  (rready),
      .snap_valid_o    (snap_valid),
      .snap_ready_i    (snap_ready),
      .snap_idx_o      (snap_idx),
      .snap_data_o     (snap_data),
      .snap_last_o     (snap_last)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // AXI read slave: one outstanding read, optional random ready/valid delays.
   bit   ar_hs, r_hs, r_out, prev_arv;
   int   r_wait, r_idx, exp_ar;
   logic [AW-1:0] prev_ara, ea;
   always @(negedge clk) begin
      if (!rst_n) begin
         arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
         ar_hs = 1'b0; r_hs = 1'b0; r_out = 1'b0; prev_arv = 1'b0; exp_ar = 0;
      end else begin
         if (prev_arv && !ar_hs) begin
            check("arvalid_hold", 64'(arvalid), 64'(1));
            check("araddr_hold", 64'(araddr), 64'(prev_ara));
         end
         if (r_hs) begin
            rvalid = 1'b0;
            r_out  = 1'b0;
         end
         if (ar_hs) begin
            r_out  = 1'b1;
            r_wait = rand_mode ? int'($urandom_range(3, 0)) : 0;
         end
         if (r_out && !rvalid) begin
            if (r_wait == 0) begin
               rvalid = 1'b1;
               rdata  = mem[r_idx];
               rresp  = (r_idx == err_idx) ? 2'b10 : 2'b00;
            end else begin
               r_wait--;
            end
         end
         arready = !r_out && (rand_mode ? 1'($urandom_range(1, 0)) : 1'b1);
         ar_hs   = arvalid && arready;
         if (ar_hs) begin
            ea = AW'(4 * exp_ar);
            check("araddr", 64'(araddr), 64'(ea));
            r_idx  = int'(araddr >> 2);
            exp_ar = (exp_ar == N - 1) ? 0 : exp_ar + 1;
         end
         r_hs     = rvalid && rready;
         prev_arv = arvalid;
         prev_ara = araddr;
      end
   end

   // Stream sink: pops the scoreboard on every accepted word.
   bit   prev_sv, prev_shs;
   logic [4:0]    prev_idx;
   logic [DW-1:0] prev_data;
   exp_t e;
   always @(negedge clk) begin
      if (!rst_n) begin
         snap_ready = 1'b0; prev_sv = 1'b0; prev_shs = 1'b0;
      end else begin
         if (prev_sv && !prev_shs) begin
            check("snap_valid_hold", 64'(snap_valid), 64'(1));
            check("snap_idx_hold", 64'(snap_idx), 64'(prev_idx));
            check("snap_data_hold", 64'(snap_data), 64'(prev_data));
         end
         snap_ready = hold_ready ? 1'b0 : (rand_mode ? 1'($urandom_range(1, 0)) : 1'b1);
         prev_shs   = snap_valid && snap_ready;
         if (prev_shs) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $error("FAIL sb_unexpected_word: observed idx=%0d expected=no word", snap_idx);
            end else begin
               e = q.pop_front();
               check("snap_idx", 64'(snap_idx), 64'(e.idx));
               check("snap_data", 64'(snap_data), 64'(e.data));
               check("snap_last", 64'(snap_last), 64'(e.last));
            end
         end
         prev_sv   = snap_valid;
         prev_idx  = snap_idx;
         prev_data = snap_data;
      end
   end

   // Sweep-start and drop monitor.
   int cyc = 0;
   int drop_cnt = 0;
   int rises[$];
   bit prev_busy = 1'b0;
   always @(negedge clk) begin
      cyc++;
      if (drop === 1'b1) drop_cnt++;
      if (busy === 1'b1 && !prev_busy) rises.push_back(cyc);
      prev_busy = (busy === 1'b1);
   end

   task automatic new_mem();
      for (int i = 0; i < N; i++) mem[i] = $urandom;
   endtask

   task automatic push_sweep();
      exp_t x;
      for (int i = 0; i < N; i++) begin
         x.idx  = 5'(i);
         x.data = mem[i];
         x.last = (i == N - 1);
         q.push_back(x);
      end
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int n = 0;
      while ((busy || q.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(n < bound), 64'(1));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_drop"}, 64'(drop), 64'(0));
      check({tag, "_err"}, 64'(err), 64'(0));
      check({tag, "_araddr"}, 64'(araddr), 64'(0));
      check({tag, "_arvalid"}, 64'(arvalid), 64'(0));
      check({tag, "_rready"}, 64'(rready), 64'(0));
      check({tag, "_snap_valid"}, 64'(snap_valid), 64'(0));
      check({tag, "_snap_idx"}, 64'(snap_idx), 64'(0));
      check({tag, "_snap_data"}, 64'(snap_data), 64'(0));
      check({tag, "_snap_last"}, 64'(snap_last), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc, n, r0;
      rst_n = 1'b0; en = 1'b1; period = '0; trig = 1'b0;
      new_mem();
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Triggered sweep on a zero-wait slave: latency and sweep length.
      new_mem(); push_sweep();
      pulse_trig();
      check("t1_arvalid_low", 64'(arvalid), 64'(0));
      @(negedge clk);
      check("t2_arvalid_high", 64'(arvalid), 64'(1));
      check("t2_araddr", 64'(araddr), 64'(0));
      bc = 0;
      while (busy && bc < 200) begin
         bc++;
         @(negedge clk);
      end
      check("busy_len", 64'(bc), 64'(57));
      check("sb_drained_trig", 64'(q.size()), 64'(0));

      // Periodic sweeps every 100 cycles without drops.
      new_mem(); repeat (3) push_sweep();
      rises.delete(); drop_cnt = 0; period = 100;
      n = 0;
      while (rises.size() < 3 && n < 400) begin
         @(negedge clk);
         n++;
      end
      en = 1'b0; period = '0;
      check("timer_sweeps", 64'(rises.size()), 64'(3));
      if (rises.size() == 3) begin
         check("timer_gap1", 64'(rises[1] - rises[0]), 64'(100));
         check("timer_gap2", 64'(rises[2] - rises[1]), 64'(100));
      end
      wait_idle("timer_idle", 400);
      check("timer_drops", 64'(drop_cnt), 64'(0));
      en = 1'b1;
      @(negedge clk);

      // Sink backpressure: stall at idx 0, one pending, later ticks dropped.
      new_mem(); push_sweep();
      hold_ready = 1'b1; drop_cnt = 0; rises.delete(); period = 10;
      repeat (95) @(negedge clk);
      en = 1'b0; period = '0;
      repeat (3) @(negedge clk);
      check("stall_idx", 64'(snap_idx), 64'(0));
      check("stall_valid", 64'(snap_valid), 64'(1));
      check("stall_busy", 64'(busy), 64'(1));
      check("stall_drops", 64'(drop_cnt), 64'(7));
      check("stall_sweeps", 64'(rises.size()), 64'(1));
      hold_ready = 1'b0;
      wait_idle("stall_idle", 200);
      repeat (20) @(negedge clk);
      check("stall_no_resweep", 64'(rises.size()), 64'(1));
      check("stall_busy_low", 64'(busy), 64'(0));
      en = 1'b1;

      // Error response on idx 5: word still pushed, err sticky.
      new_mem(); push_sweep();
      err_idx = 5;
      check("err_before", 64'(err), 64'(0));
      pulse_trig();
      wait_idle("err_idle", 200);
      check("err_set", 64'(err), 64'(1));
      err_idx = -1;
      new_mem(); push_sweep();
      pulse_trig();
      wait_idle("err_idle2", 200);
      check("err_sticky", 64'(err), 64'(1));

      // Random handshake delays; en dropped mid-sweep finishes without restart.
      rand_mode = 1'b1;
      new_mem(); push_sweep();
      pulse_trig();
      wait_idle("rand_idle", 3000);
      new_mem(); push_sweep();
      pulse_trig();
      n = 0;
      while (!(snap_valid && snap_idx == 5) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("rand_reach_idx5", 64'(n < 2000), 64'(1));
      en = 1'b0;
      r0 = rises.size();
      pulse_trig();
      wait_idle("rand_en_low_idle", 3000);
      repeat (20) @(negedge clk);
      check("rand_no_new_sweep", 64'(rises.size()), 64'(r0));
      check("rand_busy_low", 64'(busy), 64'(0));
      rand_mode = 1'b0;
      en = 1'b1;

      // Asynchronous reset at idx 7, then a clean restart from idx 0.
      new_mem(); push_sweep();
      pulse_trig();
      n = 0;
      while (!(snap_valid && snap_idx == 7) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("arst_reach_idx7", 64'(n < 500), 64'(1));
      #2 rst_n = 1'b0;
      #1 check_zero("arst");
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      new_mem(); push_sweep();
      pulse_trig();
      @(negedge clk);
      check("restart_arvalid", 64'(arvalid), 64'(1));
      check("restart_idx", 64'(snap_idx), 64'(0));
      wait_idle("restart_idle", 200);
      check("restart_err_clear", 64'(err), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
